// File: rtl/alu_op_sequencer.sv
// Serial issuer for the 16-bit combinational ALU: reads operands from a small
// register file, drives the ALU for one cycle, writes back and returns a response.
module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake rule for both channels: a transfer happens at a rising clk edge
  // where valid && ready; the initiator holds its payload until then.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [AW-1:0]     req_rd,
  input  logic [AW-1:0]     req_rs1,
  input  logic [AW-1:0]     req_rs2,
  input  logic              req_imm_en,
  input  logic [DATA_W-1:0] req_imm,
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_flag,
  output logic              rsp_dz,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] OP_DIV = 4'b0011;

  state_t            state;
  logic [DATA_W-1:0] rf [NREG];
  logic [AW-1:0]     rd_q;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              is_cmp;
  logic              is_dz;

  // Register 0 is hardwired to zero on the read side; it is never written.
  assign rs1_val = (req_rs1 == '0) ? '0 : rf[req_rs1];
  assign rs2_val = (req_rs2 == '0) ? '0 : rf[req_rs2];

  // alu_sel doubles as the latched op code while the operation is in flight.
  assign is_cmp = (alu_sel[3:1] == 3'b111);
  assign is_dz  = (alu_sel == OP_DIV) && (alu_b == '0);

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      alu_sel  <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rd_q     <= '0;
      rsp_data <= '0;
      rsp_flag <= 1'b0;
      rsp_dz   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_sel <= req_op;
            alu_a   <= rs1_val;
            alu_b   <= req_imm_en ? req_imm : rs2_val;
            rd_q    <= req_rd;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_dz) begin
            rsp_data <= '1;
            rsp_flag <= 1'b0;
            rsp_dz   <= 1'b1;
          end else begin
            rsp_data <= alu_out;
            // alu_zero is only trustworthy for the compare ops.
            rsp_flag <= is_cmp ? alu_zero : (alu_out == '0);
            rsp_dz   <= 1'b0;
            if (rd_q != '0) rf[rd_q] <= alu_out;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: ALU stub, timeline-driven driver, register-file
// model with an expected-response queue, and a per-cycle compare process.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [2:0]  req_rd;
  logic [2:0]  req_rs1;
  logic [2:0]  req_rs2;
  logic        req_imm_en;
  logic [15:0] req_imm;
  logic [3:0]  alu_sel;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_flag;
  logic        rsp_dz;
  logic [1:0]  dbg_state;

  alu_op_sequencer #(.DATA_W(16), .NREG(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm_en(req_imm_en), .req_imm(req_imm),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_dz(rsp_dz),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU stub ----------------
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a * b;
      4'h3: r = (b == 16'h0) ? 16'hDEAD : a / b;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~(a | b);
      4'h8: r = a << b[3:0];
      4'h9: r = a >> b[3:0];
      4'hA: r = $unsigned($signed(a) >>> b[3:0]);
      4'hB: r = {15'b0, $signed(a) < $signed(b)};
      4'hC: r = {15'b0, a < b};
      4'hD: r = ~(a & b);
      4'hE: r = {15'b0, a == b};
      default: r = {15'b0, a != b};
    endcase
    return r;
  endfunction

  // alu_zero carries garbage for non-compare ops so a sequencer that samples it there is caught.
  logic zero_junk;
  always @(negedge clk) zero_junk <= 1'($urandom_range(0, 1));
  always_comb begin
    alu_out  = alu_fn(alu_sel, alu_a, alu_b);
    alu_zero = (alu_sel == 4'hE) ? (alu_a == alu_b) :
               (alu_sel == 4'hF) ? (alu_a != alu_b) : zero_junk;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];         // {data, flag, dz}
  logic [15:0] model_rf [8];
  logic        exp_ready;
  logic        exp_valid;
  logic        exp_issue;
  logic [3:0]  exp_sel;
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
    if (exp_issue) begin
      chk("alu_sel", {28'b0, alu_sel}, {28'b0, exp_sel});
      chk("alu_a", {16'b0, alu_a}, {16'b0, exp_a});
      chk("alu_b", {16'b0, alu_b}, {16'b0, exp_b});
    end
    if (exp_valid && exp_q.size() > 0) begin
      chk("rsp_data", {16'b0, rsp_data}, {16'b0, exp_q[0][17:2]});
      chk("rsp_flag", {31'b0, rsp_flag}, {31'b0, exp_q[0][1]});
      chk("rsp_dz", {31'b0, rsp_dz}, {31'b0, exp_q[0][0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble_req();
    req_op     = 4'($urandom_range(0, 15));
    req_rd     = 3'($urandom_range(0, 7));
    req_rs1    = 3'($urandom_range(0, 7));
    req_rs2    = 3'($urandom_range(0, 7));
    req_imm_en = 1'($urandom_range(0, 1));
    req_imm    = 16'($urandom);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0;
    exp_q.delete();
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_issue = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_alu_sel"}, {28'b0, alu_sel}, 32'd0);
    chk({tag, "_alu_a"}, {16'b0, alu_a}, 32'd0);
    chk({tag, "_alu_b"}, {16'b0, alu_b}, 32'd0);
    chk({tag, "_rsp_data"}, {16'b0, rsp_data}, 32'd0);
    chk({tag, "_rsp_flag"}, {31'b0, rsp_flag}, 32'd0);
    chk({tag, "_rsp_dz"}, {31'b0, rsp_dz}, 32'd0);
  endtask

  // Called at posedge+#1 with the sequencer idle; returns at posedge+#1 idle again.
  task automatic do_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm,
                       input int stall, input bit lit_en, input logic [15:0] lit_data,
                       input logic lit_flag, input logic lit_dz);
    logic [15:0] a, b, res;
    logic        flag, dz;
    a  = (rs1 == 3'd0) ? 16'h0 : model_rf[rs1];
    b  = imm_en ? imm : ((rs2 == 3'd0) ? 16'h0 : model_rf[rs2]);
    dz = (op == 4'h3) && (b == 16'h0);
    if (dz) begin
      res  = 16'hFFFF;
      flag = 1'b0;
    end else begin
      res  = alu_fn(op, a, b);
      flag = (op == 4'hE) ? (a == b) : (op == 4'hF) ? (a != b) : (res == 16'h0);
    end
    req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_imm_en = imm_en; req_imm = imm; req_valid = 1'b1;
    exp_sel = op; exp_a = a; exp_b = b;
    @(posedge clk); #1;
    req_valid = 1'($urandom_range(0, 1));
    scramble_req();
    exp_ready = 1'b0;
    exp_issue = 1'b1;
    @(posedge clk); #1;
    exp_issue = 1'b0;
    exp_valid = 1'b1;
    exp_q.push_back({res, flag, dz});
    if (!dz && rd != 3'd0) model_rf[rd] = res;
    if (lit_en) begin
      chk("lit_data", {16'b0, rsp_data}, {16'b0, lit_data});
      chk("lit_flag", {31'b0, rsp_flag}, {31'b0, lit_flag});
      chk("lit_dz", {31'b0, rsp_dz}, {31'b0, lit_dz});
    end
    rsp_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      scramble_req();
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
    void'(exp_q.pop_front());
    req_valid = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit (state %0d)", dbg_state);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    scramble_req();
    clear_model();
    exp_sel = 4'h0; exp_a = 16'h0; exp_b = 16'h0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    check_reset_outputs("reset_held");
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // load idiom
    do_op(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 0, 1, 16'h0005, 1'b0, 1'b0);
    do_op(4'h0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003, 0, 1, 16'h0003, 1'b0, 1'b0);
    // arithmetic / logic with r1=5, r2=3
    do_op(4'h1, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 0, 1, 16'h0002, 1'b0, 1'b0);
    do_op(4'h2, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0, 0, 1, 16'h000F, 1'b0, 1'b0);
    do_op(4'h7, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0, 0, 1, 16'hFFF8, 1'b0, 1'b0);
    do_op(4'h1, 3'd6, 3'd1, 3'd1, 1'b0, 16'h0, 0, 1, 16'h0000, 1'b1, 1'b0);
    do_op(4'h0, 3'd0, 3'd3, 3'd0, 1'b0, 16'h0, 0, 1, 16'h0002, 1'b0, 1'b0);
    // compares
    do_op(4'hE, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0, 0, 1, 16'h0000, 1'b0, 1'b0);
    do_op(4'hF, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0, 0, 1, 16'h0001, 1'b1, 1'b0);
    // divide by zero, then confirm r7 untouched, then a legal divide
    do_op(4'h3, 3'd7, 3'd1, 3'd0, 1'b0, 16'h0, 0, 1, 16'hFFFF, 1'b0, 1'b1);
    do_op(4'h0, 3'd0, 3'd7, 3'd0, 1'b0, 16'h0, 0, 1, 16'h0000, 1'b1, 1'b0);
    do_op(4'h3, 3'd0, 3'd1, 3'd2, 1'b0, 16'h0, 0, 1, 16'h0001, 1'b0, 1'b0);
    // write to r0 discarded
    do_op(4'h0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h7777, 0, 1, 16'h7777, 1'b0, 1'b0);
    do_op(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 0, 1, 16'h0000, 1'b1, 1'b0);
    // backpressure with a competing request held high during the stall
    do_op(4'h6, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 5, 1, 16'h0006, 1'b0, 1'b0);
    do_op(4'h0, 3'd0, 3'd3, 3'd0, 1'b0, 16'h0, 0, 1, 16'h0006, 1'b0, 1'b0);

    // reset during ISSUE
    req_op = 4'h0; req_rd = 3'd1; req_rs1 = 3'd0; req_rs2 = 3'd0;
    req_imm_en = 1'b1; req_imm = 16'h1234; req_valid = 1'b1;
    exp_sel = 4'h0; exp_a = 16'h0; exp_b = 16'h1234;
    @(posedge clk); #1;
    exp_ready = 1'b0;
    exp_issue = 1'b1;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset_outputs("midop_reset");
    @(posedge clk); #1;
    check_reset_outputs("midop_reset_held");
    rst_n = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    do_op(4'h0, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0, 0, 1, 16'h0000, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [15:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      do_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm,
            int'($urandom_range(0, 3)), 0, 16'h0, 1'b0, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential issuer for the 16-bit combinational ALU: accepts register-level operation requests over a valid/ready handshake, reads operands from an internal register file, drives the ALU select and operand inputs, captures the ALU result and zero flag, writes the result back, and returns a response. It is the initiator side of the ALU interface and sits between the instruction/control path and the ALU datapath.

## Interface

- DATA_W, 16, operand/result width (must match the ALU)
- NREG, 8, number of general registers; register 0 reads as zero
- AW, 3, register address width, log2(NREG)

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready at a clk edge
- req_op  input  4  ALU op code; same encoding as the ALU select (0000 ADD … 1111 BNE)
- req_rd  input  AW  destination register
- req_rs1  input  AW  operand A register
- req_rs2  input  AW  operand B register
- req_imm_en  input  1  1: operand B = req_imm instead of register rs2
- req_imm  input  DATA_W  immediate operand
- alu_sel  output  4  to ALU select
- alu_a  output  DATA_W  to ALU operand A
- alu_b  output  DATA_W  to ALU operand B
- alu_out  input  DATA_W  from ALU result
- alu_zero  input  1  from ALU zero flag (meaningful only for ops 1110/1111)
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a clk edge
- rsp_data  output  DATA_W  result of the completed op
- rsp_flag  output  1  condition flag of the completed op
- rsp_dz  output  1  divide-by-zero on the completed op

## Operation

- States: IDLE, ISSUE, RESP. req_ready = (state == IDLE); rsp_valid = (state == RESP).
- IDLE: on request handshake, register alu_sel <= req_op, alu_a <= R[rs1], alu_b <= (req_imm_en ? req_imm : R[rs2]), and latch rd/op. Go to ISSUE.
- R[0] always reads 0; writes to R[0] are discarded. ADD with rs1 = 0 and req_imm_en = 1 is the register-load idiom.
- ISSUE: alu_* are held stable for the whole cycle. At the closing edge:
  - Capture rsp_data <= alu_out.
  - rsp_flag <= alu_zero for op 1110/1111; otherwise rsp_flag <= (alu_out == 0).
  - Write R[rd] <= alu_out (unless rd = 0). Go to RESP.
- Divide by zero: op 0011 with alu_b == 0. alu_out is ignored; rsp_data <= 16'hFFFF, rsp_dz <= 1, rsp_flag <= 0, no register write. For every other op, rsp_dz <= 0.
- alu_zero is never sampled for ops other than 1110/1111, because the ALU drives it X or stale there.
- RESP: rsp_data/rsp_flag/rsp_dz held stable while rsp_valid && !rsp_ready. On response handshake, go to IDLE.
- Operations are strictly serialized, so there are no read-after-write hazards; a request sees all prior write-backs.
- Arithmetic is modulo 2^16 as delivered by the ALU; the sequencer does not widen or saturate.

## Timing

- Reset (rst_n low, asynchronous): state = IDLE; all R[i] = 0.
  - Outputs: alu_sel = 0, alu_a = 0, alu_b = 0, rsp_data = 0, rsp_flag = 0, rsp_dz = 0, rsp_valid = 0, req_ready = 1.
  - A request with req_valid high while rst_n is low is not accepted.
- Latency: request handshake at edge E0 → alu_* valid after E0 → result captured and written at E1 → rsp_valid high after E1 (2 cycles).
- Minimum initiation interval is 3 cycles (accept, issue, respond with rsp_ready already high).
- req_ready is low from E0 until the edge that completes the response handshake. A new request can be accepted in the cycle following that edge, not in the same edge.
- Reset asserted during ISSUE or RESP abandons the operation: no write-back after reset, the response is lost, and the register file is cleared.
- Any change of req_* while req_ready is low has no effect.

## Test plan

- Load: ADD rd=1 rs1=0 imm_en=1 imm=0005, then rd=2 imm=0003 → rsp_data 0005 then 0003, rsp_flag 0; rsp_valid exactly 2 cycles after each accept.
- Arithmetic/logic with r1 = 5, r2 = 3:
  - SUB rd=3 → 0002.
  - MUL rd=4 → 000F.
  - NOR rd=5 → FFF8.
  - SUB rd=6 rs1=1 rs2=1 → 0000 with rsp_flag 1.
  - Read back r3 via ADD rs2=0 → 0002.
- Compare: BEQ r1,r2 → rsp_data 0000, rsp_flag = alu_zero = 0; BNE r1,r2 → 0001, flag 1. Drive alu_zero = X during ADD and confirm rsp_flag is not X.
- Divide by zero: DIV rd=7 rs1=1 rs2=0 → rsp_data FFFF, rsp_dz 1; a later read of r7 returns its prior value (0). DIV r1/r2 → 0001, rsp_dz 0.
- Backpressure: hold rsp_ready low 5 cycles → rsp_valid and rsp_data stable and req_ready low throughout; a request presented meanwhile is accepted only after the response handshake.
- Reset mid-op: assert rst_n low during ISSUE of "ADD rd=1 imm=1234" → after release all outputs are at reset values, rsp_valid 0, and a read of r1 returns 0000.
